// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx
//   Bit-serial UART transmitter draining the 6551 output FIFO onto a physical
//   TXD pin. Frame format (bitrate, data bits, parity, stop bits) comes from
//   the serial status word and is latched once per frame. Baud timing uses a
//   fractional accumulator that issues half-bit ticks.
//
// Ports
//   CLK                        system clock
//   RESET_N                    asynchronous active-low reset
//   ENABLE                     1 = new frames may start
//   serial_data_out_available  FIFO used count (nonzero = byte present)
//   serial_data_out            FIFO head byte
//   serial_status_out          format word (bitrate bytes, databits, parity, stopbits)
//   serial_strobe_out          one-CLK pop pulse to the FIFO
//   CTS                        clear to send, sampled in IDLE only
//   TXD                        registered serial output, idle high
//   BUSY                       high whenever not IDLE
//   FRAME_DONE                 one-CLK pulse on the last CLK of the stop period
module uart_fifo_tx #(
    parameter int unsigned CLK_HZ = 32000000,
    parameter int unsigned ACC_W  = 32
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic [7:0]  serial_data_out_available,
    input  logic [7:0]  serial_data_out,
    input  logic [31:0] serial_status_out,
    output logic        serial_strobe_out,
    input  logic        CTS,
    output logic        TXD,
    output logic        BUSY,
    output logic        FRAME_DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state, state_d;
    logic [ACC_W-1:0] acc, acc_d;
    logic [ACC_W:0]   acc_sum;
    logic             tick;
    logic [7:0]       shreg, shreg_d;
    logic             par, par_d;
    logic [2:0]       half, half_d;
    logic [2:0]       bitcnt, bitcnt_d;
    logic             txd_d;

    // live decode of the format word
    logic [23:0]      rate_live;
    logic [3:0]       dbits_live;
    logic             par_en_live, par_odd_live;
    logic [2:0]       stop_live;

    // format frozen for the duration of a frame
    logic [23:0]      rate_q;
    logic [3:0]       dbits_q;
    logic             par_en_q, par_odd_q;
    logic [2:0]       stop_ticks_q;

    assign rate_live = {serial_status_out[15:8], serial_status_out[23:16], serial_status_out[31:24]};

    always_comb begin
        case (serial_status_out[7:4])
            4'd5, 4'd6, 4'd7, 4'd8: dbits_live = serial_status_out[7:4];
            default:                dbits_live = 4'd8;
        endcase
        par_en_live  = (serial_status_out[3:2] == 2'd1) || (serial_status_out[3:2] == 2'd2);
        par_odd_live = (serial_status_out[3:2] == 2'd1);
        case (serial_status_out[1:0])
            2'd0:    stop_live = 3'd2;
            2'd1:    stop_live = 3'd3;
            default: stop_live = 3'd4;
        endcase
    end

    // half-bit tick: acc accumulates 2*bitrate per CLK and wraps at CLK_HZ
    assign acc_sum = {1'b0, acc} + (ACC_W+1)'({rate_q, 1'b0});
    assign tick    = (acc_sum >= (ACC_W+1)'(CLK_HZ));

    // state and datapath registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= S_IDLE;
            acc    <= '0;
            shreg  <= '0;
            par    <= 1'b0;
            half   <= '0;
            bitcnt <= '0;
            TXD    <= 1'b1;
        end else begin
            state  <= state_d;
            acc    <= acc_d;
            shreg  <= shreg_d;
            par    <= par_d;
            half   <= half_d;
            bitcnt <= bitcnt_d;
            TXD    <= txd_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rate_q       <= '0;
            dbits_q      <= 4'd8;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            stop_ticks_q <= 3'd2;
        end else if (state == S_LOAD) begin
            rate_q       <= rate_live;
            dbits_q      <= dbits_live;
            par_en_q     <= par_en_live;
            par_odd_q    <= par_odd_live;
            stop_ticks_q <= stop_live;
        end
    end

    // next-state and next-datapath logic
    always_comb begin
        state_d  = state;
        acc_d    = acc;
        shreg_d  = shreg;
        par_d    = par;
        half_d   = half;
        bitcnt_d = bitcnt;
        case (state)
            S_IDLE: begin
                if (ENABLE && CTS && (serial_data_out_available != 8'd0) && (rate_live != 24'd0))
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                acc_d    = '0;
                shreg_d  = serial_data_out;
                par_d    = 1'b0;
                half_d   = '0;
                bitcnt_d = '0;
                state_d  = S_START;
            end
            default: begin
                acc_d = tick ? ACC_W'(acc_sum - (ACC_W+1)'(CLK_HZ)) : acc_sum[ACC_W-1:0];
                if (tick) begin
                    case (state)
                        S_START: begin
                            if (half == 3'd1) begin
                                half_d  = '0;
                                state_d = S_DATA;
                            end else begin
                                half_d = half + 3'd1;
                            end
                        end
                        S_DATA: begin
                            if (half == 3'd1) begin
                                half_d   = '0;
                                shreg_d  = shreg >> 1;
                                par_d    = par ^ shreg[0];
                                bitcnt_d = bitcnt + 3'd1;
                                if (({1'b0, bitcnt} + 4'd1) == dbits_q)
                                    state_d = par_en_q ? S_PARITY : S_STOP;
                            end else begin
                                half_d = half + 3'd1;
                            end
                        end
                        S_PARITY: begin
                            if (half == 3'd1) begin
                                half_d  = '0;
                                state_d = S_STOP;
                            end else begin
                                half_d = half + 3'd1;
                            end
                        end
                        S_STOP: begin
                            if (half == stop_ticks_q - 3'd1) begin
                                half_d  = '0;
                                state_d = S_IDLE;
                            end else begin
                                half_d = half + 3'd1;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // outputs; TXD is registered from the upcoming state so the start bit
    // appears the CLK right after the pop strobe
    always_comb begin
        serial_strobe_out = (state == S_LOAD);
        BUSY              = (state != S_IDLE);
        FRAME_DONE        = (state == S_STOP) && tick && (half == stop_ticks_q - 3'd1);
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shreg_d[0];
            S_PARITY: txd_d = par_d ^ par_odd_q;
            default:  txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
module tb_uart_fifo_tx;

    localparam longint CLK_HZ_TB = 1843200;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        ENABLE;
    logic [7:0]  serial_data_out_available;
    logic [7:0]  serial_data_out;
    logic [31:0] serial_status_out;
    logic        serial_strobe_out;
    logic        CTS;
    logic        TXD;
    logic        BUSY;
    logic        FRAME_DONE;

    uart_fifo_tx #(.CLK_HZ(1843200), .ACC_W(32)) dut (
        .CLK                       (CLK),
        .RESET_N                   (RESET_N),
        .ENABLE                    (ENABLE),
        .serial_data_out_available (serial_data_out_available),
        .serial_data_out           (serial_data_out),
        .serial_status_out         (serial_status_out),
        .serial_strobe_out         (serial_strobe_out),
        .CTS                       (CTS),
        .TXD                       (TXD),
        .BUSY                      (BUSY),
        .FRAME_DONE                (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    // 230400 baud at 1.8432 MHz: 8 CLK per bit
    localparam logic [31:0] FMT_8N1   = 32'h0084_0380;
    localparam logic [31:0] FMT_7E1   = 32'h0084_0378;
    localparam logic [31:0] FMT_7O15  = 32'h0084_0375;
    localparam logic [31:0] FMT_ZERO  = 32'h0000_0080;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic longint rate_of(input logic [31:0] s);
        return longint'({s[15:8], s[23:16], s[31:24]});
    endfunction

    // FIFO stand-in
    logic [7:0] fifo[$];
    int popped = 0;

    task automatic upd_fifo();
        serial_data_out_available = 8'(fifo.size());
        serial_data_out = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endtask

    // reference model: per-frame list of half-bit slots, timed by the
    // ideal tick count floor(c * 2*bitrate / CLK_HZ)
    int     mphase = 0;
    longint mc, mlen, mrate;
    int     nslots;
    bit     slots[0:31];

    task build_frame(input logic [7:0] b, input logic [31:0] s);
        int db, pm, sh;
        bit x, pb;
        mrate = rate_of(s);
        db = int'(s[7:4]);
        if (db < 5 || db > 8) db = 8;
        pm = int'(s[3:2]);
        sh = (s[1:0] == 2'd0) ? 2 : (s[1:0] == 2'd1) ? 3 : 4;
        nslots = 0;
        x = 1'b0;
        slots[nslots++] = 1'b0; slots[nslots++] = 1'b0;
        for (int i = 0; i < db; i++) begin
            slots[nslots++] = b[i]; slots[nslots++] = b[i];
            x ^= b[i];
        end
        if (pm == 1 || pm == 2) begin
            pb = (pm == 2) ? x : ~x;
            slots[nslots++] = pb; slots[nslots++] = pb;
        end
        for (int i = 0; i < sh; i++) slots[nslots++] = 1'b1;
        mlen = (longint'(nslots) * CLK_HZ_TB + 2 * mrate - 1) / (2 * mrate);
    endtask

    // observation counters
    longint cyc = 0;
    int     strobe_cnt = 0;
    int     fd_cnt = 0;
    longint strobe_cyc = 0, first_low = 0, last_fd = 0, gap = 0;
    bit     look_low = 1'b0;
    logic [9:0] cap = '0;
    logic   e_txd, e_busy, e_stb, e_fd;
    longint off;
    int     idx;

    always @(negedge CLK) begin
        cyc++;
        if (!RESET_N) begin
            mphase = 0;
            e_txd = 1'b1; e_busy = 1'b0; e_stb = 1'b0; e_fd = 1'b0;
        end else begin
            case (mphase)
                0: begin
                    e_txd = 1'b1; e_busy = 1'b0; e_stb = 1'b0; e_fd = 1'b0;
                    if (ENABLE && CTS && serial_data_out_available != 8'd0 &&
                        rate_of(serial_status_out) != 0)
                        mphase = 1;
                end
                1: begin
                    e_txd = 1'b1; e_busy = 1'b1; e_stb = 1'b1; e_fd = 1'b0;
                    build_frame(serial_data_out, serial_status_out);
                    mc = 1;
                    mphase = 2;
                end
                default: begin
                    idx = int'(((mc - 1) * 2 * mrate) / CLK_HZ_TB);
                    if (idx >= nslots) idx = nslots - 1;
                    e_txd = slots[idx]; e_busy = 1'b1; e_stb = 1'b0;
                    e_fd = (mc == mlen);
                    if (mc == mlen) mphase = 0;
                    else mc++;
                end
            endcase
        end
        chk("txd", TXD, e_txd);
        chk("busy", BUSY, e_busy);
        chk("strobe", serial_strobe_out, e_stb);
        chk("frame_done", FRAME_DONE, e_fd);

        if (RESET_N) begin
            if (serial_strobe_out) begin
                strobe_cnt++;
                strobe_cyc = cyc;
                cap = '0;
                look_low = 1'b1;
            end else if (look_low && TXD == 1'b0) begin
                first_low = cyc;
                look_low = 1'b0;
                gap = first_low - last_fd;
            end
            if (cyc > strobe_cyc) begin
                off = cyc - strobe_cyc - 1;
                if (off % 8 == 3 && off / 8 < 10) cap[int'(off / 8)] = TXD;
            end
            if (FRAME_DONE) begin
                fd_cnt++;
                last_fd = cyc;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            while (popped < strobe_cnt) begin
                if (fifo.size() > 0) void'(fifo.pop_front());
                popped++;
            end
            upd_fifo();
        end
    endtask

    task automatic wait_fd(input int target, input int budget);
        int k = 0;
        while (fd_cnt < target && k < budget) begin step(1); k++; end
        chk("frame_done_wait", fd_cnt, target);
    endtask

    task automatic wait_strobe(input int target, input int budget);
        int k = 0;
        while (strobe_cnt < target && k < budget) begin step(1); k++; end
        chk("strobe_wait", strobe_cnt, target);
    endtask

    initial begin
        RESET_N = 1'b0; ENABLE = 1'b0; CTS = 1'b0;
        serial_status_out = '0;
        upd_fifo();
        step(2);
        chk("reset_txd", TXD, 1);
        chk("reset_busy", BUSY, 0);
        chk("reset_strobe", serial_strobe_out, 0);
        chk("reset_fd", FRAME_DONE, 0);
        RESET_N = 1'b1;
        step(3);

        // 8N1, 0x55
        serial_status_out = FMT_8N1; ENABLE = 1'b1; CTS = 1'b1;
        fifo.push_back(8'h55); upd_fifo();
        wait_fd(1, 200);
        chk("t1_bits", cap, 10'h2AA);
        chk("t1_fall_after_strobe", first_low - strobe_cyc, 1);
        chk("t1_frame_len", last_fd - strobe_cyc, 80);
        chk("t1_strobes", strobe_cnt, 1);

        // 7E1, 0xC1: bit 7 must not appear
        step(5);
        serial_status_out = FMT_7E1;
        fifo.push_back(8'hC1); upd_fifo();
        wait_fd(2, 200);
        chk("t2_bits", cap, 10'h282);
        chk("t2_frame_len", last_fd - strobe_cyc, 80);

        // 7O1.5, 0x03; format word changed mid-frame must not matter
        step(5);
        serial_status_out = FMT_7O15;
        fifo.push_back(8'h03); upd_fifo();
        wait_strobe(3, 50);
        step(20);
        serial_status_out = FMT_8N1;
        wait_fd(3, 200);
        chk("t3_bits", cap, 10'h306);
        chk("t3_frame_len", last_fd - strobe_cyc, 84);

        // three queued bytes back to back
        step(5);
        fifo.push_back(8'hA5); fifo.push_back(8'h0F); fifo.push_back(8'h3C); upd_fifo();
        chk("t4_avail", serial_data_out_available, 3);
        wait_fd(4, 200);
        wait_fd(5, 200);
        chk("t4_gap2", gap, 3);
        wait_fd(6, 200);
        chk("t4_gap3", gap, 3);
        step(30);
        chk("t4_strobes", strobe_cnt, 6);
        chk("t4_fifo_empty", fifo.size(), 0);

        // CTS low blocks; CTS drop mid-frame lets the frame finish
        CTS = 1'b0;
        fifo.push_back(8'h11); fifo.push_back(8'h22); upd_fifo();
        step(50);
        chk("t5_no_strobe", strobe_cnt, 6);
        chk("t5_txd_idle", TXD, 1);
        chk("t5_not_busy", BUSY, 0);
        CTS = 1'b1;
        wait_strobe(7, 20);
        step(20);
        CTS = 1'b0;
        wait_fd(7, 200);
        step(40);
        chk("t5_held", strobe_cnt, 7);
        CTS = 1'b1;
        wait_fd(8, 200);
        chk("t5_resumed", strobe_cnt, 8);

        // asynchronous reset mid-DATA
        step(5);
        fifo.push_back(8'h5A); upd_fifo();
        wait_strobe(9, 20);
        step(20);
        chk("t6_busy_before", BUSY, 1);
        RESET_N = 1'b0;
        #1;
        chk("t6_reset_txd", TXD, 1);
        chk("t6_reset_busy", BUSY, 0);
        step(2);
        RESET_N = 1'b1;
        step(20);
        chk("t6_no_restart", strobe_cnt, 9);

        // bitrate zero never pops
        serial_status_out = FMT_ZERO;
        fifo.push_back(8'h77); fifo.push_back(8'h88); upd_fifo();
        step(100);
        chk("t6_zero_rate", strobe_cnt, 9);
        chk("t6_zero_rate_fifo", fifo.size(), 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
